// File: rtl/rename_ctrl_pkg.sv
// Shared types and defaults for the register-rename controller.
package rename_ctrl_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned REG_ID_W  = 5;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_RECOVER
    } rename_state_e;

endpackage

// File: rtl/rename_ctrl_if.sv
// Dispatch, commit/flush and rename-map write bundle between the dispatch stage and rename_ctrl.
interface rename_ctrl_if
    import rename_ctrl_pkg::*;
#(
    parameter int unsigned DATA  = $bits(reg_id_t),
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned WRITE = 2
);
    localparam int unsigned ADDR = $clog2(DEPTH);

    logic [WRITE-1:0]      dis_req;
    logic [WRITE-1:0]      dis_v;
    logic [WRITE*DATA-1:0] dis_rd;
    logic [WRITE-1:0]      dis_ack;
    logic [WRITE*ADDR-1:0] dis_tag;
    logic                  com_e_;
    logic                  flush_req_;
    logic [WRITE-1:0]      map_we_;
    logic [WRITE-1:0]      map_wv;
    logic [WRITE*DATA-1:0] map_wd;
    logic [WRITE*ADDR-1:0] map_waddr;
    logic                  map_flush_;
    logic                  map_inve_;
    logic [ADDR-1:0]       map_invaddr;
    logic                  rob_full;
    logic                  rob_empty;
    logic                  busy;

    modport master (
        output dis_req, dis_v, dis_rd, com_e_, flush_req_,
        input  dis_ack, dis_tag, map_we_, map_wv, map_wd, map_waddr,
               map_flush_, map_inve_, map_invaddr, rob_full, rob_empty, busy
    );

    modport slave (
        input  dis_req, dis_v, dis_rd, com_e_, flush_req_,
        output dis_ack, dis_tag, map_we_, map_wv, map_wd, map_waddr,
               map_flush_, map_inve_, map_invaddr, rob_full, rob_empty, busy
    );

endinterface

// File: rtl/rename_ctrl.sv
// Reorder-buffer tag allocator: grants in-order dispatch lanes, retires the oldest entry,
// and drives the external rename map's write/invalidate/flush ports with zero added latency.
module rename_ctrl
    import rename_ctrl_pkg::*;
#(
    parameter int unsigned DATA  = $bits(reg_id_t),
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned WRITE = 2,
    localparam int unsigned ADDR = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    rename_ctrl_if.slave bus
);

    localparam int unsigned CW = ADDR + 1;

    rename_state_e   state_q, state_d;
    logic [ADDR-1:0] head_q, head_d;
    logic [ADDR-1:0] tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            flush_c;
    logic            run_c;
    logic            chain_c;
    logic            commit_c;
    logic [CW-1:0]   free_c;
    logic [CW-1:0]   n_grant_c;
    logic [CW-1:0]   tail_sum_c;
    logic [WRITE-1:0] ack_c;

    // Grants use registered occupancy only, so slots freed by a same-cycle commit stay unused.
    always_comb begin
        flush_c   = !reset && !bus.flush_req_;
        run_c     = !reset && (state_q == ST_RUN) && bus.flush_req_;
        free_c    = CW'(DEPTH) - count_q;
        ack_c     = '0;
        n_grant_c = '0;
        chain_c   = 1'b1;
        for (int unsigned i = 0; i < WRITE; i++) begin
            chain_c   = chain_c & bus.dis_req[i];
            ack_c[i]  = run_c && chain_c && (free_c >= CW'(i + 1));
            n_grant_c = n_grant_c + CW'(ack_c[i]);
        end
        commit_c = run_c && !bus.com_e_ && (count_q != '0);
    end

    for (genvar g = 0; g < WRITE; g++) begin : g_lane
        logic [CW-1:0] tag_sum;

        always_comb begin
            tag_sum = CW'(tail_q) + CW'(g);
            if (tag_sum >= CW'(DEPTH)) tag_sum = tag_sum - CW'(DEPTH);
        end

        assign bus.dis_ack[g]                = ack_c[g];
        assign bus.dis_tag[g*ADDR +: ADDR]   = tag_sum[ADDR-1:0];
        assign bus.map_we_[g]                = !ack_c[g];
        assign bus.map_wv[g]                 = bus.dis_v[g];
        assign bus.map_wd[g*DATA +: DATA]    = bus.dis_rd[g*DATA +: DATA];
        assign bus.map_waddr[g*ADDR +: ADDR] = tag_sum[ADDR-1:0];
    end

    assign bus.map_flush_  = !flush_c;
    assign bus.map_inve_   = !commit_c;
    assign bus.map_invaddr = head_q;
    assign bus.rob_full    = (count_q == CW'(DEPTH));
    assign bus.rob_empty   = (count_q == '0);
    assign bus.busy        = (state_q != ST_RUN);

    // Next state: flush overrides everything and empties the buffer on the same edge.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        tail_sum_c = CW'(tail_q) + n_grant_c;
        if (tail_sum_c >= CW'(DEPTH)) tail_sum_c = tail_sum_c - CW'(DEPTH);

        unique case (state_q)
            ST_RUN:     state_d = ST_RUN;
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        if (run_c) begin
            tail_d  = tail_sum_c[ADDR-1:0];
            count_d = count_q + n_grant_c - CW'(commit_c);
            if (commit_c) begin
                head_d = (head_q == ADDR'(DEPTH - 1)) ? '0 : head_q + ADDR'(1);
            end
        end

        if (flush_c) begin
            state_d = ST_FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: directed vector table, reset corner cases and a
// randomized run against an occupancy/pointer reference model.
module tb_rename_ctrl;
    import rename_ctrl_pkg::*;

    localparam int unsigned DATA  = $bits(reg_id_t);
    localparam int unsigned DEPTH = ROB_DEPTH;
    localparam int unsigned WRITE = 2;
    localparam int unsigned ADDR  = $clog2(DEPTH);
    localparam int          NVEC  = 19;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rename_ctrl_if #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE)) bus ();

    rename_ctrl #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] v;
        logic       com_n;
        logic       fl_n;
        logic [1:0] ack;
        logic       flush_n;
        logic       inve_n;
        logic       busy;
        logic       full;
        logic       empty;
        int         tag0;
    } vec_t;

    int errors;
    int checks;

    // Reference model: plain ring-buffer bookkeeping; st 0=run, 1=flush, 2=recover
    int m_head, m_tail, m_cnt, m_st;

    logic [WRITE-1:0]      cur_req, cur_v;
    logic [WRITE*DATA-1:0] cur_rd;
    logic                  cur_com_n, cur_fl_n;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [WRITE-1:0] req, input logic [WRITE-1:0] v,
                         input logic [WRITE*DATA-1:0] rd, input logic com_n, input logic fl_n);
        cur_req = req; cur_v = v; cur_rd = rd; cur_com_n = com_n; cur_fl_n = fl_n;
        bus.dis_req    = req;
        bus.dis_v      = v;
        bus.dis_rd     = rd;
        bus.com_e_     = com_n;
        bus.flush_req_ = fl_n;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic model_check();
        bit run, commit;
        int k, free, d;
        logic [WRITE-1:0] e_ack, e_we;
        d    = int'(DEPTH);
        run  = (m_st == 0) && cur_fl_n;
        free = d - m_cnt;
        k    = 0;
        if (run) while (k < int'(WRITE) && cur_req[k] && k < free) k++;
        e_ack = '0;
        for (int i = 0; i < k; i++) e_ack[i] = 1'b1;
        e_we   = ~e_ack;
        commit = run && !cur_com_n && (m_cnt > 0);

        chk("dis_ack", int'(bus.dis_ack), int'(e_ack));
        chk("map_we_", int'(bus.map_we_), int'(e_we));
        for (int i = 0; i < k; i++) begin
            chk("dis_tag", int'(bus.dis_tag[i*ADDR +: ADDR]), (m_tail + i) % d);
            chk("map_waddr", int'(bus.map_waddr[i*ADDR +: ADDR]), (m_tail + i) % d);
        end
        chk("map_wv", int'(bus.map_wv), int'(cur_v));
        chk("map_wd", int'(bus.map_wd), int'(cur_rd));
        chk("map_flush_", int'(bus.map_flush_), int'(cur_fl_n));
        chk("map_inve_", int'(bus.map_inve_), int'(!commit));
        if (commit) chk("map_invaddr", int'(bus.map_invaddr), m_head);
        chk("rob_full", int'(bus.rob_full), int'(m_cnt == d));
        chk("rob_empty", int'(bus.rob_empty), int'(m_cnt == 0));
        chk("busy", int'(bus.busy), int'(m_st != 0));

        if (!cur_fl_n) begin
            m_st = 1; m_head = 0; m_tail = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            m_st = 2;
        end else if (m_st == 2) begin
            m_st = 0;
        end else begin
            m_tail = (m_tail + k) % d;
            m_head = (m_head + int'(commit)) % d;
            m_cnt  = m_cnt + k - int'(commit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [WRITE-1:0] ones;
        ones = '1;
        chk({tag, " dis_ack"}, int'(bus.dis_ack), 0);
        chk({tag, " map_we_"}, int'(bus.map_we_), int'(ones));
        chk({tag, " map_flush_"}, int'(bus.map_flush_), 1);
        chk({tag, " map_inve_"}, int'(bus.map_inve_), 1);
        chk({tag, " map_invaddr"}, int'(bus.map_invaddr), 0);
        chk({tag, " rob_empty"}, int'(bus.rob_empty), 1);
        chk({tag, " rob_full"}, int'(bus.rob_full), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
    endtask

    vec_t                  tbl[NVEC];
    logic [WRITE*DATA-1:0] rdv;

    initial begin
        errors = 0; checks = 0;
        m_head = 0; m_tail = 0; m_cnt = 0; m_st = 0;
        rdv = {5'd9, 5'd3};

        //          req    v      com   fl    ack    fn    inn   busy  full  empty tag0
        tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1};
        tbl[1]  = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[2]  = '{2'b11, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[3]  = '{2'b11, 2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        tbl[4]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6};
        tbl[5]  = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7};
        tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1};
        tbl[7]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[11] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[12] = '{2'b11, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[14] = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
        tbl[15] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1};
        tbl[16] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1};
        tbl[17] = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[18] = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};

        // Reset with requests, commit and flush all active: nothing may leak out
        reset          = 1'b1;
        bus.dis_req    = '1;
        bus.dis_v      = '1;
        bus.dis_rd     = '0;
        bus.com_e_     = 1'b0;
        bus.flush_req_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        bus.dis_req = '0; bus.com_e_ = 1'b1; bus.flush_req_ = 1'b1;
        reset = 1'b0;
        advance();

        for (int n = 0; n < NVEC; n++) begin
            apply(tbl[n].req, tbl[n].v, rdv, tbl[n].com_n, tbl[n].fl_n);
            chk($sformatf("vec%0d dis_ack", n), int'(bus.dis_ack), int'(tbl[n].ack));
            chk($sformatf("vec%0d map_flush_", n), int'(bus.map_flush_), int'(tbl[n].flush_n));
            chk($sformatf("vec%0d map_inve_", n), int'(bus.map_inve_), int'(tbl[n].inve_n));
            chk($sformatf("vec%0d busy", n), int'(bus.busy), int'(tbl[n].busy));
            chk($sformatf("vec%0d rob_full", n), int'(bus.rob_full), int'(tbl[n].full));
            chk($sformatf("vec%0d rob_empty", n), int'(bus.rob_empty), int'(tbl[n].empty));
            if (tbl[n].tag0 >= 0)
                chk($sformatf("vec%0d tag0", n), int'(bus.dis_tag[ADDR-1:0]), tbl[n].tag0);
            model_check();
            advance();
        end

        // Reset arriving while recovering from a flush
        apply(2'b11, 2'b11, rdv, 1'b1, 1'b1); model_check(); advance();
        apply(2'b00, 2'b00, rdv, 1'b1, 1'b0); model_check(); advance();
        apply(2'b00, 2'b00, rdv, 1'b1, 1'b1); model_check(); advance();
        chk("recover busy before reset", int'(bus.busy), 1);
        bus.dis_req = '1; bus.com_e_ = 1'b0; bus.flush_req_ = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_in_recover");
        m_st = 0; m_head = 0; m_tail = 0; m_cnt = 0;
        @(negedge clk);
        check_reset_outputs("reset_in_recover_hold");
        bus.dis_req = '0; bus.com_e_ = 1'b1; bus.flush_req_ = 1'b1;
        reset = 1'b0;
        advance();
        apply(2'b11, 2'b11, rdv, 1'b1, 1'b1);
        chk("post_reset tag0", int'(bus.dis_tag[ADDR-1:0]), 0);
        chk("post_reset tag1", int'(bus.dis_tag[2*ADDR-1:ADDR]), 1);
        model_check();
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [WRITE-1:0]      req, v;
            logic [WRITE*DATA-1:0] rd;
            logic                  com_n, fl_n;
            req   = WRITE'($urandom_range(0, 3));
            v     = WRITE'($urandom_range(0, 3));
            rd    = (WRITE*DATA)'($urandom);
            com_n = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            fl_n  = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            apply(req, v, rd, com_n, fl_n);
            model_check();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rename_ctrl.md
RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 SHALL have parameters: DATA, default $bits(RegFile_t), register-id width; DEPTH, default `RobDepth, tag count; WRITE, default 2, dispatch lanes; ADDR, default $clog2(DEPTH), tag width (constant).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- dis_req  in  WRITE  dispatch request per lane, in-order (lane i only if lanes <i)
- dis_v  in  WRITE  lane has a destination register
- dis_rd  in  WRITE*DATA  destination register id
- dis_ack  out  WRITE  lane granted this cycle
- dis_tag  out  WRITE*ADDR  tag assigned to lane
- com_e_  in  1  active-low commit of oldest entry
- flush_req_  in  1  active-low pipeline flush
- map_we_  out  WRITE  map write enable, active-low
- map_wv  out  WRITE  map write valid
- map_wd  out  WRITE*DATA  map write data
- map_waddr  out  WRITE*ADDR  map write address
- map_flush_  out  1  map clear-all, active-low
- map_inve_  out  1  map single-entry invalidate, active-low
- map_invaddr  out  ADDR  entry to invalidate
- rob_full, rob_empty, busy  out  1 each  status

Function
REQ-003 SHALL keep registered head, tail (ADDR bits, modulo DEPTH) and count (ADDR+1 bits, 0..DEPTH).
REQ-004 SHALL compute free = DEPTH - count from registered count only; entries freed by a same-cycle commit SHALL NOT be granted.
REQ-005 SHALL grant combinationally: dis_ack[i] = state RUN & flush_req_ high & dis_req[0..i] all high & free >= i+1.
REQ-006 SHALL assign dis_tag[i] = (tail + i) mod DEPTH, valid in the grant cycle.
REQ-007 SHALL drive map_we_[i] = !dis_ack[i], map_wv[i] = dis_v[i], map_wd[i] = dis_rd[i], map_waddr[i] = dis_tag[i], same cycle (zero added latency).
REQ-008 SHALL advance tail by the number of grants (0..WRITE) with wrap-around.
REQ-009 SHALL accept commit when com_e_ low, state RUN, flush_req_ high and count > 0; commit on empty SHALL be ignored with no map activity.
REQ-010 SHALL drive map_inve_ low and map_invaddr = head in an accepted-commit cycle, and advance head by 1 mod DEPTH.
REQ-011 SHALL update count = count + grants - commit for simultaneous dispatch and commit.
REQ-012 SHALL implement states RUN, FLUSH, RECOVER: RUN->FLUSH when flush_req_ low; FLUSH->RECOVER after one cycle; RECOVER->RUN after one cycle; flush_req_ low in any state SHALL (re)enter FLUSH.
REQ-013 SHALL, in the cycle flush_req_ is sampled low, drive map_flush_ low, suppress all grants and commits, and on that edge clear head, tail, count to 0.
REQ-014 SHALL suppress grants and commits in FLUSH and RECOVER; busy = (state != RUN).
REQ-015 SHALL drive rob_full = (count == DEPTH), rob_empty = (count == 0), both from registers.

Reset
REQ-016 SHALL, while reset high, asynchronously force state RUN and head = tail = count = 0.
REQ-017 SHALL hold output values during and after reset: dis_ack 0, map_we_ all 1, map_flush_ 1, map_inve_ 1, map_invaddr 0, rob_empty 1, rob_full 0, busy 0.
REQ-018 SHALL abandon any in-progress FLUSH/RECOVER on reset; no grant SHALL be issued in a reset cycle.

Structure
REQ-019 SHALL place the RUN/FLUSH/RECOVER state enum typedef in a shared header (rename.svh); DEPTH default comes from `RobDepth in cpu_config.svh, and RegFile_t from regfile.svh.
REQ-020 SHALL be a single module with no sub-module; it drives an external rename_map instance and does not instantiate it.

Verification
REQ-021 Reset, then dis_req=2'b11, dis_v=2'b11 -> dis_ack=2'b11, tags 0 and 1, map_we_=2'b00; next cycle count=2.
REQ-022 DEPTH=8, count=7, dis_req=2'b11 -> dis_ack=2'b01, tag 7; next cycle tail=0, rob_full=1.
REQ-023 count=8 with com_e_ low and dis_req=2'b01 -> dis_ack=0, map_inve_ low, invaddr=head; next cycle count=7.
REQ-024 count=3, com_e_ low and dis_req=2'b11 -> 2 grants, 1 commit; next cycle count=4.
REQ-025 flush_req_ low with count=5 and dis_req=2'b11 -> map_flush_ low, dis_ack=0; then FLUSH, RECOVER (busy=1); third cycle grants tag 0.
REQ-026 Empty, com_e_ low -> map_inve_ stays high, head unchanged; reset asserted in RECOVER -> state RUN, busy 0 immediately.
